// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-client arbiter placed in front of a single cacheline adapter.
// The adapter sees one request at a time. The winning request is captured into
// registers at grant time, so the adapter outputs never depend combinationally
// on the client inputs.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection; without it
// the lowest-index requester always wins (fixed priority, dcache over icache).
`timescale 1ns/1ps
module mem_arbiter_rr #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
  input  logic [NUM_CLIENTS-1:0]            cl_read,
  input  logic [NUM_CLIENTS-1:0]            cl_write,
  input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS*LINE_WIDTH-1:0] cl_rdata,
  output logic [NUM_CLIENTS-1:0]            cl_resp,
  output logic [ADDR_WIDTH-1:0]             address_i,
  output logic [LINE_WIDTH-1:0]             line_i,
  output logic                              read_i,
  output logic                              write_i,
  input  logic [LINE_WIDTH-1:0]             line_o,
  input  logic                              resp_o,
  output logic [NUM_CLIENTS-1:0]            grant_o,
  output logic                              busy_o
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   is_write_q, is_write_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   found;
`endif

  logic [NUM_CLIENTS-1:0] req;
  logic                   any_req;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;

  // A read+write request from the same client counts as a single read request.
  assign req     = cl_read | cl_write;
  assign any_req = |req;

  // Select the winner among the clients asking right now.
  always_comb begin
    winner = '0;
    cand   = '0;
`ifdef ARB_ROUND_ROBIN_EN
    found  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = IDX_W'((int'(last_grant_q) + 1 + i) % NUM_CLIENTS);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`else
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req[cand]) begin
        winner = cand;
      end
    end
`endif
  end

  // Next state: capture the winner's request on grant, release on adapter completion.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    gnt_d        = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d     = cl_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = cl_wdata[winner*LINE_WIDTH +: LINE_WIDTH];
          is_write_d = cl_write[winner] & ~cl_read[winner];
          gnt_d      = winner;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (resp_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      gnt_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      gnt_q        <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Adapter and client outputs, driven from captured registers; a reset cycle suppresses responses.
  always_comb begin
    address_i = '0;
    line_i    = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    grant_o   = '0;
    busy_o    = 1'b0;
    cl_resp   = '0;
    cl_rdata  = '0;
    if (state_q == BUSY) begin
      address_i      = addr_q;
      read_i         = ~is_write_q;
      write_i        = is_write_q;
      line_i         = is_write_q ? wdata_q : '0;
      grant_o[gnt_q] = 1'b1;
      busy_o         = 1'b1;
      if (resp_o && !rst) begin
        cl_resp[gnt_q] = 1'b1;
        if (!is_write_q) begin
          cl_rdata[gnt_q*LINE_WIDTH +: LINE_WIDTH] = line_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: self-checking bench for mem_arbiter_rr with four clients.
// Works for both builds (ARB_ROUND_ROBIN_EN defined or not).
`timescale 1ns/1ps
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int IW = $clog2(N);
  localparam int NV = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   cl_address;
  logic [N-1:0]      cl_read;
  logic [N-1:0]      cl_write;
  logic [N*LW-1:0]   cl_wdata;
  logic [N*LW-1:0]   cl_rdata;
  logic [N-1:0]      cl_resp;
  logic [AW-1:0]     address_i;
  logic [LW-1:0]     line_i;
  logic              read_i;
  logic              write_i;
  logic [LW-1:0]     line_o;
  logic              resp_o;
  logic [N-1:0]      grant_o;
  logic              busy_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    logic         resp;
    logic [N-1:0] expGrant;
    logic         expBusy;
    logic         expRead;
    logic         expWrite;
    logic [N-1:0] expResp;
  } vec_t;

  vec_t         vecs [NV];
  logic [N-1:0] g10, g13;
  int           expOrder [5];
  int           grants [$];
  int           idleRun;
  int           own;
  logic [AW-1:0] expAddr;
  logic [LW-1:0] expLine;
  logic [LW-1:0] tableLine;
  logic [LW-1:0] lineA5;

  // Behavioural reference model state
  bit            mBusy;
  int            mOwner;
  bit            mWr;
  logic [AW-1:0] mAddr;
  logic [LW-1:0] mData;
  int            mLast;
  int            w;
  logic          rstV, respV;
  logic [N-1:0]  rdV, wrV, eGrant, eResp;
  logic [LW-1:0] lineV;

  // Free-running clock
  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NUM_CLIENTS(N),
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cl_address(cl_address),
    .cl_read   (cl_read),
    .cl_write  (cl_write),
    .cl_wdata  (cl_wdata),
    .cl_rdata  (cl_rdata),
    .cl_resp   (cl_resp),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the control inputs for the current cycle and let them settle
  task automatic applyStimulus(input logic r, input logic [N-1:0] rd, input logic [N-1:0] wr,
                               input logic rsp);
    rst      = r;
    cl_read  = rd;
    cl_write = wr;
    resp_o   = rsp;
    #1;
  endtask

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Synchronous reset pulse with all requests dropped
  task automatic doReset();
    rst      = 1'b1;
    cl_read  = '0;
    cl_write = '0;
    resp_o   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] addrOf(input int k);
    return AW'(32'h1000_0000 + k * 64);
  endfunction

  function automatic logic [LW-1:0] wdataOf(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic int ohIdx(input logic [N-1:0] g);
    ohIdx = -1;
    if ($countones(g) == 1) begin
      for (int k = 0; k < N; k++) begin
        if (g[IW'(k)]) ohIdx = k;
      end
    end
  endfunction

  function automatic logic [LW-1:0] randomLine();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference arbitration rule: scan from last+1 with wrap (round-robin) or lowest index wins
  function automatic int pickWinner(input logic [N-1:0] req, input int last);
    int idx;
    pickWinner = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int s = 1; s <= N; s++) begin
      idx = (last + s) % N;
      if (pickWinner < 0 && req[IW'(idx)]) pickWinner = idx;
    end
`else
    idx = last;
    for (int s = 0; s < N; s++) begin
      if (pickWinner < 0 && req[IW'(s)]) pickWinner = s;
    end
`endif
  endfunction

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    g10 = 4'b0010;
    g13 = 4'b0100;
    expOrder = '{0, 1, 2, 3, 0};
`else
    g10 = 4'b0001;
    g13 = 4'b0001;
    expOrder = '{0, 0, 0, 0, 0};
`endif
    tableLine = {8{32'h5A5A_0F0F}};
    lineA5    = {32{8'hA5}};

    //                 rst   rd       wr       resp  grant    busy  rdI   wrI   resp
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001};
    vecs[9]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{1'b0, 4'b1111, 4'b0000, 1'b0, g10,     1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[11] = '{1'b0, 4'b1111, 4'b0000, 1'b1, g10,     1'b1, 1'b1, 1'b0, g10};
    vecs[12] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[13] = '{1'b0, 4'b1111, 4'b0000, 1'b0, g13,     1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[14] = '{1'b1, 4'b1111, 4'b0000, 1'b1, g13,     1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[16] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[17] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[18] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};

    // Reset state: every output low while rst is held
    rst        = 1'b1;
    cl_read    = '0;
    cl_write   = '0;
    resp_o     = 1'b0;
    line_o     = '0;
    cl_address = '0;
    cl_wdata   = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst.grant", LW'(grant_o), '0);
    checkOutput("rst.busy", LW'(busy_o), '0);
    checkOutput("rst.read", LW'(read_i), '0);
    checkOutput("rst.write", LW'(write_i), '0);
    checkOutput("rst.address", LW'(address_i), '0);
    checkOutput("rst.line", line_i, '0);
    checkOutput("rst.resp", LW'(cl_resp), '0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("rst.rdata%0d", k), cl_rdata[k*LW +: LW], '0);

    // Table-driven sequence: single read, spurious resp, write, contention, reset mid-busy
    for (int k = 0; k < N; k++) begin
      cl_address[k*AW +: AW] = addrOf(k);
      cl_wdata[k*LW +: LW]   = wdataOf(k);
    end
    line_o = tableLine;
    for (int r = 0; r < NV; r++) begin
      applyStimulus(vecs[r].rst, vecs[r].rd, vecs[r].wr, vecs[r].resp);
      own     = ohIdx(vecs[r].expGrant);
      expAddr = (vecs[r].expBusy && own >= 0) ? addrOf(own) : '0;
      expLine = (vecs[r].expWrite && own >= 0) ? wdataOf(own) : '0;
      checkOutput($sformatf("v%0d.grant", r), LW'(grant_o), LW'(vecs[r].expGrant));
      checkOutput($sformatf("v%0d.busy", r), LW'(busy_o), LW'(vecs[r].expBusy));
      checkOutput($sformatf("v%0d.read", r), LW'(read_i), LW'(vecs[r].expRead));
      checkOutput($sformatf("v%0d.write", r), LW'(write_i), LW'(vecs[r].expWrite));
      checkOutput($sformatf("v%0d.resp", r), LW'(cl_resp), LW'(vecs[r].expResp));
      checkOutput($sformatf("v%0d.address", r), LW'(address_i), LW'(expAddr));
      checkOutput($sformatf("v%0d.line", r), line_i, expLine);
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("v%0d.rdata%0d", r, k), cl_rdata[k*LW +: LW],
                    (vecs[r].expResp[IW'(k)] && vecs[r].expRead) ? tableLine : '0);
      end
      tick();
    end

    // Single read by client 1, adapter answers on the fifth busy cycle
    doReset();
    cl_address = '0;
    cl_address[1*AW +: AW] = 32'h0000_1040;
    line_o  = '0;
    cl_read = 4'b0010;
    #1;
    checkOutput("rd.idleBusy", LW'(busy_o), '0);
    tick();
    cl_read = '0;
    for (int c = 1; c <= 5; c++) begin
      resp_o = (c == 5);
      line_o = (c == 5) ? lineA5 : '0;
      #1;
      checkOutput($sformatf("rd.read%0d", c), LW'(read_i), LW'(1'b1));
      checkOutput($sformatf("rd.address%0d", c), LW'(address_i), LW'(32'h0000_1040));
      checkOutput($sformatf("rd.resp%0d", c), LW'(cl_resp), LW'((c == 5) ? 4'b0010 : 4'b0000));
      if (c == 5) begin
        checkOutput("rd.rdata1", cl_rdata[1*LW +: LW], lineA5);
        checkOutput("rd.rdata0", cl_rdata[0 +: LW], '0);
      end
      tick();
    end
    resp_o = 1'b0;
    #1;
    checkOutput("rd.respAfter", LW'(cl_resp), '0);
    checkOutput("rd.readAfter", LW'(read_i), '0);

    // Write capture: client 0 changes its address and data while busy
    doReset();
    cl_address[0 +: AW] = 32'h8000_0000;
    cl_wdata[0 +: LW]   = LW'(256'h1234);
    cl_write = 4'b0001;
    tick();
    cl_address[0 +: AW] = 32'hDEAD_BEEF;
    cl_wdata[0 +: LW]   = '1;
    for (int c = 1; c <= 3; c++) begin
      resp_o = (c == 3);
      #1;
      checkOutput($sformatf("wr.write%0d", c), LW'(write_i), LW'(1'b1));
      checkOutput($sformatf("wr.address%0d", c), LW'(address_i), LW'(32'h8000_0000));
      checkOutput($sformatf("wr.line%0d", c), line_i, LW'(256'h1234));
      tick();
    end
    cl_write = '0;
    resp_o   = 1'b0;
    #1;
    checkOutput("wr.lineAfter", line_i, '0);
    checkOutput("wr.writeAfter", LW'(write_i), '0);

    // Contention: all clients request continuously, adapter always ready
    doReset();
    cl_read = '1;
    resp_o  = 1'b1;
    idleRun = 0;
    grants.delete();
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      #1;
      if (busy_o) begin
        checkOutput($sformatf("cont.gap%0d", grants.size()), LW'(idleRun), LW'(1));
        grants.push_back(ohIdx(grant_o));
        idleRun = 0;
      end else begin
        idleRun++;
      end
      tick();
    end
    checkOutput("cont.count", LW'(grants.size()), LW'(5));
    for (int g = 0; g < grants.size() && g < 5; g++) begin
      checkOutput($sformatf("cont.order%0d", g), LW'(grants[g]), LW'(expOrder[g]));
    end
    resp_o  = 1'b0;
    cl_read = '0;

    // Randomized traffic against the reference model
    mBusy  = 1'b0;
    mOwner = 0;
    mWr    = 1'b0;
    mAddr  = '0;
    mData  = '0;
    mLast  = N - 1;
    for (int c = 0; c < 1500; c++) begin
      rstV  = (c == 0) || ($urandom_range(0, 79) == 0);
      rdV   = N'($urandom & $urandom);
      wrV   = N'($urandom & $urandom);
      respV = ($urandom_range(0, 2) == 0);
      lineV = randomLine();
      for (int k = 0; k < N; k++) begin
        cl_address[k*AW +: AW] = $urandom;
        cl_wdata[k*LW +: LW]   = randomLine();
      end
      line_o = lineV;
      applyStimulus(rstV, rdV, wrV, respV);

      eGrant = mBusy ? (N'(1) << mOwner) : '0;
      eResp  = (mBusy && respV && !rstV) ? eGrant : '0;
      checkOutput("rnd.grant", LW'(grant_o), LW'(eGrant));
      checkOutput("rnd.busy", LW'(busy_o), LW'(mBusy));
      checkOutput("rnd.read", LW'(read_i), LW'(mBusy && !mWr));
      checkOutput("rnd.write", LW'(write_i), LW'(mBusy && mWr));
      checkOutput("rnd.address", LW'(address_i), mBusy ? LW'(mAddr) : '0);
      checkOutput("rnd.line", line_i, (mBusy && mWr) ? mData : '0);
      checkOutput("rnd.resp", LW'(cl_resp), LW'(eResp));
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("rnd.rdata%0d", k), cl_rdata[k*LW +: LW],
                    (eResp[IW'(k)] && !mWr) ? lineV : '0);
      end

      if (rstV) begin
        mBusy = 1'b0;
        mLast = N - 1;
      end else if (!mBusy) begin
        w = pickWinner(rdV | wrV, mLast);
        if (w >= 0) begin
          mBusy  = 1'b1;
          mOwner = w;
          mAddr  = cl_address[w*AW +: AW];
          mData  = cl_wdata[w*LW +: LW];
          mWr    = wrV[IW'(w)] && !rdV[IW'(w)];
          mLast  = w;
        end
      end else if (respV) begin
        mBusy = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
